pcie_io_rx_engine: RTL

Receive-side PIO engine of the PCIe DMA path. Accepts 64-bit AXI-stream TLPs from the PCIe hard-core RX interface and decodes single-DW memory/IO requests. Writes go to the local register/memory port. Non-posted requests raise a completion request with captured header fields for the downstream TX engine (`pcie_io_tx_engine`), then stall RX until that engine reports completion done.

---
 rtl/pcie_dma_pkg.sv | 60 ++++++
 rtl/pcie_io_rx_engine.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pcie_dma_pkg.sv
// Shared PCIe DMA definitions: TLP fmt/type codes, RX parser state encoding,
// and the captured completion-request register bundle.
package pcie_dma_pkg;

    localparam logic [6:0] FMT_MRD32 = 7'h00;
    localparam logic [6:0] FMT_MRD64 = 7'h20;
    localparam logic [6:0] FMT_MWR32 = 7'h40;
    localparam logic [6:0] FMT_MWR64 = 7'h60;
    localparam logic [6:0] FMT_IOWR  = 7'h42;
    localparam logic [6:0] FMT_IORD  = 7'h02;
    localparam logic [6:0] FMT_CPL   = 7'h0A;
    localparam logic [6:0] FMT_CPLD  = 7'h4A;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_RD32_DW2 = 4'd1,
        ST_RD64_DW2 = 4'd2,
        ST_WR32_DW2 = 4'd3,
        ST_WR64_DW2 = 4'd4,
        ST_WR64_DW3 = 4'd5,
        ST_IOWR_DW2 = 4'd6,
        ST_WAIT_WR  = 4'd7,
        ST_WAIT_CPL = 4'd8,
        ST_DISCARD  = 4'd9
    } rx_state_e;

    typedef struct packed {
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [7:0]  be;
        logic [12:0] addr;
        logic        compl_wd;
    } req_regs_t;

    localparam req_regs_t REQ_REGS_RST = '0;

    // State entered after header beat 0; anything not a 1-DW supported request is dropped.
    function automatic rx_state_e rx_first_state(input logic [6:0] ft, input logic one_dw,
                                                 input logic last);
        rx_state_e st;
        st = last ? ST_RST : ST_DISCARD;
        if (one_dw) begin
            case (ft)
                FMT_MRD32, FMT_IORD: st = ST_RD32_DW2;
                FMT_MRD64:           st = ST_RD64_DW2;
                FMT_MWR32:           st = ST_WR32_DW2;
                FMT_MWR64:           st = ST_WR64_DW2;
                FMT_IOWR:            st = ST_IOWR_DW2;
                default:             st = last ? ST_RST : ST_DISCARD;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/pcie_io_rx_engine.sv
// Receive-side PIO engine: parses 1-DW memory/IO request TLPs from a 64-bit
// AXI-stream, issues local writes and hands completion requests to the TX engine.
module pcie_io_rx_engine
    import pcie_dma_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [C_DATA_WIDTH-1:0] i_m_axis_rx_tdata,
    input  logic [KEEP_WIDTH-1:0]   i_m_axis_rx_tkeep,
    input  logic                    i_m_axis_rx_tlast,
    input  logic                    i_m_axis_rx_tvalid,
    output logic                    o_m_axis_rx_tready,
    output logic                    o_req_compl,
    output logic                    o_req_compl_wd,
    input  logic                    i_compl_done,
    output logic [2:0]              o_req_tc,
    output logic                    o_req_td,
    output logic                    o_req_ep,
    output logic [1:0]              o_req_attr,
    output logic [9:0]              o_req_len,
    output logic [15:0]             o_req_rid,
    output logic [7:0]              o_req_tag,
    output logic [7:0]              o_req_be,
    output logic [12:0]             o_req_addr,
    output logic [10:0]             o_wr_addr,
    output logic [3:0]              o_wr_be,
    output logic [31:0]             o_wr_data,
    output logic                    o_wr_en,
    input  logic                    i_wr_busy,
    output logic [3:0]              o_dbg_state
);

    // Handshake: a beat transfers on a rising edge where tvalid and the registered
    // tready are both 1; tready is computed from the next state so it drops in the
    // same update that enters WAIT_WR/WAIT_CPL.
    rx_state_e   state_q, state_d;
    req_regs_t   req_q, req_d;
    logic        tready_q, tready_d;
    logic        compl_q, compl_d;
    logic        owe_q, owe_d;
    logic        wr_en_q, wr_en_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [3:0]  wr_be_q, wr_be_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        beat;
    logic [31:0] dw_lo, dw_hi;
    logic        unused_ok;

    assign beat      = i_m_axis_rx_tvalid & tready_q;
    assign dw_lo     = i_m_axis_rx_tdata[31:0];
    assign dw_hi     = i_m_axis_rx_tdata[63:32];
    assign unused_ok = ^{i_m_axis_rx_tkeep, i_m_axis_rx_tdata};

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        owe_d     = owe_q;
        compl_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_be_d   = wr_be_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_RST: begin
                if (beat) begin
                    state_d = rx_first_state(dw_lo[30:24], dw_lo[9:0] == 10'd1, i_m_axis_rx_tlast);
                    if (state_d != ST_RST && state_d != ST_DISCARD) begin
                        req_d.tc       = dw_lo[22:20];
                        req_d.td       = dw_lo[15];
                        req_d.ep       = dw_lo[14];
                        req_d.attr     = dw_lo[13:12];
                        req_d.len      = dw_lo[9:0];
                        req_d.rid      = dw_hi[31:16];
                        req_d.tag      = dw_hi[15:8];
                        req_d.be       = dw_hi[7:0];
                        req_d.addr     = '0;
                        req_d.compl_wd = (state_d == ST_RD32_DW2) || (state_d == ST_RD64_DW2);
                        owe_d          = (state_d == ST_IOWR_DW2);
                        wr_be_d        = dw_hi[3:0];
                    end
                end
            end
            ST_RD32_DW2, ST_RD64_DW2: begin
                if (beat) begin
                    req_d.addr = (state_q == ST_RD32_DW2) ? {dw_lo[12:2], 2'b00}
                                                          : {dw_hi[12:2], 2'b00};
                    compl_d    = 1'b1;
                    state_d    = ST_WAIT_CPL;
                end
            end
            ST_WR32_DW2, ST_IOWR_DW2: begin
                if (beat) begin
                    wr_addr_d  = dw_lo[12:2];
                    req_d.addr = {dw_lo[12:2], 2'b00};
                    wr_data_d  = dw_hi;
                    wr_en_d    = 1'b1;
                    state_d    = ST_WAIT_WR;
                end
            end
            ST_WR64_DW2: begin
                if (beat) begin
                    wr_addr_d  = dw_hi[12:2];
                    req_d.addr = {dw_hi[12:2], 2'b00};
                    state_d    = ST_WR64_DW3;
                end
            end
            ST_WR64_DW3: begin
                if (beat) begin
                    wr_data_d = dw_lo;
                    wr_en_d   = 1'b1;
                    state_d   = ST_WAIT_WR;
                end
            end
            ST_WAIT_WR: begin
                if (!i_wr_busy) begin
                    if (owe_q) begin
                        owe_d   = 1'b0;
                        compl_d = 1'b1;
                        state_d = ST_WAIT_CPL;
                    end else begin
                        state_d = ST_RST;
                    end
                end
            end
            ST_WAIT_CPL: begin
                // A done coincident with the request pulse belongs to an earlier request.
                if (i_compl_done && !compl_q) state_d = ST_RST;
            end
            ST_DISCARD: begin
                if (beat && i_m_axis_rx_tlast) state_d = ST_RST;
            end
            default: state_d = ST_RST;
        endcase
        tready_d = (state_d != ST_WAIT_WR) && (state_d != ST_WAIT_CPL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_RST;
            req_q     <= REQ_REGS_RST;
            tready_q  <= 1'b0;
            compl_q   <= 1'b0;
            owe_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            tready_q  <= tready_d;
            compl_q   <= compl_d;
            owe_q     <= owe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_m_axis_rx_tready = tready_q;
    assign o_req_compl        = compl_q;
    assign o_req_compl_wd     = req_q.compl_wd;
    assign o_req_tc           = req_q.tc;
    assign o_req_td           = req_q.td;
    assign o_req_ep           = req_q.ep;
    assign o_req_attr         = req_q.attr;
    assign o_req_len          = req_q.len;
    assign o_req_rid          = req_q.rid;
    assign o_req_tag          = req_q.tag;
    assign o_req_be           = req_q.be;
    assign o_req_addr         = req_q.addr;
    assign o_wr_addr          = wr_addr_q;
    assign o_wr_be            = wr_be_q;
    assign o_wr_data          = wr_data_q;
    assign o_wr_en            = wr_en_q;
    assign o_dbg_state        = state_q;

endmodule
